regfile_access_sequencer: RTL

- Owns the 8-bit register file's select, write-enable and write-data inputs, and shares them between two requesters: the core execute stage and the debug port.
- Provides 8-bit reads and writes, plus 16-bit pair operations (BC/DE/HL read, write, increment, decrement).
- A 16-bit write needs two cycles because the register file has one write port. This block splits each such operation into per-byte cycles.
- Sits between the execute stage / debug bridge and the register file. It never drives the flag inputs; a 16-bit increment or decrement leaves F unchanged.

---
 rtl/gb_regfile_pkg.sv | 62 ++++++
 rtl/rf_rr_arbiter.sv | 35 +++
 rtl/regfile_access_sequencer.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/gb_regfile_pkg.sv
// Shared codes, enums and pair mapping for the register-file access sequencer.
package gb_regfile_pkg;

    localparam int unsigned REG_W  = 3;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned WIDE_W = 16;

    localparam logic [REG_W-1:0] REG_A       = 3'd0;
    localparam logic [REG_W-1:0] REG_B       = 3'd1;
    localparam logic [REG_W-1:0] REG_C       = 3'd2;
    localparam logic [REG_W-1:0] REG_D       = 3'd3;
    localparam logic [REG_W-1:0] REG_E       = 3'd4;
    localparam logic [REG_W-1:0] REG_H       = 3'd5;
    localparam logic [REG_W-1:0] REG_L       = 3'd6;
    localparam logic [REG_W-1:0] REG_ILLEGAL = 3'd7;

    localparam logic [1:0] PAIR_BC      = 2'd0;
    localparam logic [1:0] PAIR_DE      = 2'd1;
    localparam logic [1:0] PAIR_HL      = 2'd2;
    localparam logic [1:0] PAIR_ILLEGAL = 2'd3;

    typedef enum logic [2:0] {
        OP_READ8   = 3'd0,
        OP_WRITE8  = 3'd1,
        OP_READ16  = 3'd2,
        OP_WRITE16 = 3'd3,
        OP_INC16   = 3'd4,
        OP_DEC16   = 3'd5
    } rf_op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC1 = 2'd1,
        EXEC2 = 2'd2,
        DONE  = 2'd3
    } seq_state_t;

    // Latched request payload
    typedef struct packed {
        logic [2:0]        op;
        logic [REG_W-1:0]  rsel;
        logic [WIDE_W-1:0] wdata;
    } rf_req_t;

    typedef struct packed {
        logic [REG_W-1:0] hi;
        logic [REG_W-1:0] lo;
    } pair_regs_t;

    // Pair code to {high, low} register codes; high byte is the first-named register
    function automatic pair_regs_t pair_regs(input logic [1:0] pair);
        pair_regs_t r;
        case (pair)
            PAIR_BC: r = '{hi: REG_B, lo: REG_C};
            PAIR_DE: r = '{hi: REG_D, lo: REG_E};
            PAIR_HL: r = '{hi: REG_H, lo: REG_L};
            default: r = '{hi: REG_A, lo: REG_A};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/rf_rr_arbiter.sv
// Two-way request arbiter with optional round-robin tie-break.
module rf_rr_arbiter #(
    parameter bit ROUND_ROBIN = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       core_req,
    input  logic       dbg_req,
    input  logic       take,
    output logic [1:0] grant_c
);

    // High when debug was the most recent grant
    logic last_dbg_q;

    // One-hot grant: bit 0 core, bit 1 debug
    always_comb begin
        grant_c = 2'b00;
        if (core_req && dbg_req) begin
            if (ROUND_ROBIN && !last_dbg_q) grant_c = 2'b10;
            else                            grant_c = 2'b01;
        end else if (core_req) begin
            grant_c = 2'b01;
        end else if (dbg_req) begin
            grant_c = 2'b10;
        end
    end

    // Remember who was granted last
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                     last_dbg_q <= 1'b1;
        else if (take && |grant_c)    last_dbg_q <= grant_c[1];
    end

endmodule

// File: rtl/regfile_access_sequencer.sv
// Shares the register file write port between core and debug, splitting 16-bit ops into byte cycles.
module regfile_access_sequencer #(
    parameter bit ROUND_ROBIN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        core_req,
    input  logic [2:0]  core_op,
    input  logic [2:0]  core_reg,
    input  logic [15:0] core_wdata,
    output logic        core_done,
    input  logic        dbg_req,
    input  logic [2:0]  dbg_op,
    input  logic [2:0]  dbg_reg,
    input  logic [15:0] dbg_wdata,
    output logic        dbg_done,
    output logic [15:0] rdata,
    output logic        err,
    output logic        busy,
    output logic [2:0]  rf_sel_a,
    output logic [2:0]  rf_sel_b,
    output logic        rf_load_en,
    output logic [7:0]  rf_wr_data,
    input  logic [7:0]  rf_out_a,
    input  logic [7:0]  rf_out_b
);
    import gb_regfile_pkg::*;

    seq_state_t        state_q, state_d;
    rf_req_t           req_q, req_d;
    logic              owner_q;
    logic [BYTE_W-1:0] temp_q, temp_d;
    logic [WIDE_W-1:0] rdata_d;
    logic              err_d;
    logic              take;
    logic [1:0]        grant_c;
    pair_regs_t        pr;
    logic              is16, bad;
    logic [WIDE_W-1:0] pair_val, pair_res;

    rf_rr_arbiter #(.ROUND_ROBIN(ROUND_ROBIN)) u_arb (
        .clk      (clk),
        .rst      (rst),
        .core_req (core_req),
        .dbg_req  (dbg_req),
        .take     (take),
        .grant_c  (grant_c)
    );

    // Payload of whichever requester wins this cycle
    assign req_d = grant_c[1] ? rf_req_t'({dbg_op, dbg_reg, dbg_wdata})
                              : rf_req_t'({core_op, core_reg, core_wdata});

    // Operand decode and 16-bit increment/decrement arithmetic
    always_comb begin
        pr       = pair_regs(req_q.rsel[1:0]);
        is16     = (req_q.op >= 3'(OP_READ16)) && (req_q.op <= 3'(OP_DEC16));
        bad      = (req_q.op > 3'(OP_DEC16)) ||
                   (is16 ? (req_q.rsel[1:0] == PAIR_ILLEGAL) : (req_q.rsel == REG_ILLEGAL));
        pair_val = {rf_out_b, rf_out_a};
        pair_res = (req_q.op == 3'(OP_INC16)) ? pair_val + 16'd1 : pair_val - 16'd1;
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Next state, register-file drive and capture values
    always_comb begin
        state_d    = state_q;
        take       = 1'b0;
        rf_sel_a   = 3'd0;
        rf_sel_b   = 3'd0;
        rf_load_en = 1'b0;
        rf_wr_data = 8'd0;
        temp_d     = temp_q;
        rdata_d    = rdata;
        err_d      = err;
        case (state_q)
            IDLE: begin
                if (core_req || dbg_req) begin
                    take    = 1'b1;
                    rdata_d = 16'd0;
                    err_d   = 1'b0;
                    state_d = EXEC1;
                end
            end
            EXEC1: begin
                state_d = DONE;
                if (bad) begin
                    rdata_d = 16'd0;
                    err_d   = 1'b1;
                end else begin
                    case (req_q.op)
                        OP_READ8: begin
                            rf_sel_a = req_q.rsel;
                            rdata_d  = {8'h00, rf_out_a};
                        end
                        OP_WRITE8: begin
                            rf_sel_a   = req_q.rsel;
                            rf_wr_data = req_q.wdata[7:0];
                            rf_load_en = 1'b1;
                        end
                        OP_READ16: begin
                            rf_sel_a = pr.lo;
                            rf_sel_b = pr.hi;
                            rdata_d  = pair_val;
                        end
                        OP_WRITE16: begin
                            rf_sel_a   = pr.lo;
                            rf_wr_data = req_q.wdata[7:0];
                            rf_load_en = 1'b1;
                            temp_d     = req_q.wdata[15:8];
                            state_d    = EXEC2;
                        end
                        default: begin
                            rf_sel_a   = pr.lo;
                            rf_sel_b   = pr.hi;
                            rf_wr_data = pair_res[7:0];
                            rf_load_en = 1'b1;
                            temp_d     = pair_res[15:8];
                            rdata_d    = pair_res;
                            state_d    = EXEC2;
                        end
                    endcase
                end
            end
            EXEC2: begin
                rf_sel_a   = pr.hi;
                rf_wr_data = temp_q;
                rf_load_en = 1'b1;
                state_d    = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Request latch, temp byte and registered status outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_q     <= '0;
            owner_q   <= 1'b0;
            temp_q    <= 8'd0;
            rdata     <= 16'd0;
            err       <= 1'b0;
            busy      <= 1'b0;
            core_done <= 1'b0;
            dbg_done  <= 1'b0;
        end else begin
            if (take) begin
                req_q   <= req_d;
                owner_q <= grant_c[1];
            end
            temp_q    <= temp_d;
            rdata     <= rdata_d;
            err       <= err_d;
            busy      <= (state_d != IDLE);
            core_done <= (state_d == DONE) && !owner_q;
            dbg_done  <= (state_d == DONE) && owner_q;
        end
    end

endmodule
